aes_round_sequencer: RTL and testbench

Control sequencer for the area-optimised, column-serial AES-128 encryption datapath. It accepts one plaintext/key pair through a valid/ready handshake and steps the shared column datapath through the initial AddRoundKey and the rounds. It drives the column select, round number, key-schedule step and Rcon, S-box enable and MixColumns bypass, then holds the result until the consumer accepts it. It sits beside the multi-run controller and is driven by it on the input and output handshakes.

---
 rtl/aes_round_sequencer.sv | 176 +++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Control sequencer for the column-serial AES-128 encryption datapath.
// Steps the shared column datapath through the initial AddRoundKey and all cipher rounds.
module aes_round_sequencer #(
   parameter int NUM_ROUNDS       = 10,
   parameter int CYCLES_PER_ROUND = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       load_en,
   output logic       state_we,
   output logic [1:0] col_sel,
   output logic [3:0] round,
   output logic       key_step,
   output logic [7:0] rcon,
   output logic       sb_en,
   output logic       mc_bypass,
   output logic       busy,
   output logic       done
);

   generate
      if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_num_rounds
         $fatal(1, "aes_round_sequencer: NUM_ROUNDS must be in 1..10");
      end
      if (CYCLES_PER_ROUND != 2 && CYCLES_PER_ROUND != 4) begin : g_bad_cpr
         $fatal(1, "aes_round_sequencer: CYCLES_PER_ROUND must be 2 or 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ARK0,
      ROUND,
      HOLD
   } state_e;

   localparam logic [1:0] LAST_COL   = 2'(CYCLES_PER_ROUND - 1);
   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
   localparam logic [7:0] RCON_INIT  = 8'h01;

   state_e     state_q, state_d;
   logic [1:0] col_q, col_d;
   logic [3:0] round_q, round_d;
   logic [7:0] rcon_q, rcon_d;
   logic       done_q, done_d;

   // GF(2^8) doubling: next round constant from the current one.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= 2'd0;
         round_q <= 4'd0;
         rcon_q  <= RCON_INIT;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         round_q <= round_d;
         rcon_q  <= rcon_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      round_d = round_q;
      rcon_d  = rcon_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = ARK0;
            col_d   = 2'd0;
            round_d = 4'd0;
         end
         ARK0: begin
            if (col_q == LAST_COL) begin
               state_d = ROUND;
               round_d = 4'd1;
               col_d   = 2'd0;
            end else begin
               col_d = col_q + 2'd1;
            end
         end
         ROUND: begin
            if (col_q == LAST_COL) begin
               if (round_q < LAST_ROUND) begin
                  round_d = round_q + 4'd1;
                  col_d   = 2'd0;
                  rcon_d  = xtime(rcon_q);
               end else begin
                  state_d = HOLD;
               end
            end else begin
               col_d = col_q + 2'd1;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
               round_d = 4'd0;
               col_d   = 2'd0;
               rcon_d  = RCON_INIT;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Everything is forced low while reset is held, even before the state register settles.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load_en   = 1'b0;
      state_we  = 1'b0;
      col_sel   = 2'd0;
      round     = 4'd0;
      key_step  = 1'b0;
      rcon      = 8'h00;
      sb_en     = 1'b0;
      mc_bypass = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      if (!rst) begin
         col_sel = col_q;
         round   = round_q;
         done    = done_q;
         case (state_q)
            IDLE: begin
               in_ready = 1'b1;
            end
            LOAD: begin
               load_en = 1'b1;
               busy    = 1'b1;
            end
            ARK0: begin
               state_we = 1'b1;
               busy     = 1'b1;
            end
            ROUND: begin
               state_we  = 1'b1;
               sb_en     = 1'b1;
               busy      = 1'b1;
               key_step  = (col_q == 2'd0);
               rcon      = (col_q == 2'd0) ? rcon_q : 8'h00;
               mc_bypass = (round_q == LAST_ROUND);
            end
            HOLD: begin
               out_valid = 1'b1;
               busy      = 1'b1;
            end
            default: begin
               busy = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: the driver queues expected acceptance cycles,
// a negedge monitor checks per-job timing, Rcon sequence, hold stability and done pulses.
module tb_aes_round_sequencer;

   localparam int NUM_ROUNDS = 10;
   localparam int CPR        = 4;
   localparam int LATENCY    = 45;
   localparam int SPACING    = 47;
   localparam logic [7:0] RCON_EXP [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic       load_en;
   logic       state_we;
   logic [1:0] col_sel;
   logic [3:0] round;
   logic       key_step;
   logic [7:0] rcon;
   logic       sb_en;
   logic       mc_bypass;
   logic       busy;
   logic       done;
   logic [21:0] other_outs;

   int cyc = 0;
   int n_checks = 0;
   int n_fails = 0;
   int exp_q[$];
   int expected_dones = 0;
   int seen_dones = 0;

   aes_round_sequencer #(
      .NUM_ROUNDS(NUM_ROUNDS),
      .CYCLES_PER_ROUND(CPR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .load_en(load_en),
      .state_we(state_we),
      .col_sel(col_sel),
      .round(round),
      .key_step(key_step),
      .rcon(rcon),
      .sb_en(sb_en),
      .mc_bypass(mc_bypass),
      .busy(busy),
      .done(done)
   );

   assign other_outs = {out_valid, load_en, state_we, col_sel, round, key_step,
                        rcon, sb_en, mc_bypass, busy, done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, actual, actual, expected, expected, cyc);
      end
   endtask

   // Raise in_valid, wait for the handshake edge and queue its cycle; returns after that edge.
   task automatic applyStimulus(output int accept, input bit keep_valid);
      int n;
      bit got;
      n = 0;
      got = 0;
      accept = -1;
      in_valid = 1'b1;
      while (!got && n < 200) begin
         @(negedge clk);
         if (in_ready) got = 1;
         n++;
      end
      if (!got) begin
         checkOutput("accept_timeout", 0, 1);
      end else begin
         accept = cyc + 1;
         exp_q.push_back(accept);
         expected_dones++;
      end
      @(posedge clk);
      #1;
      if (!keep_valid) in_valid = 1'b0;
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (seen_dones < expected_dones && n < 300);
      if (seen_dones < expected_dones) checkOutput("done_timeout", seen_dones, expected_dones);
      #1;
   endtask

   initial begin : monitor
      int n_load, n_we, n_sb, n_mc, key_idx, a;
      logic prev_ov;
      n_load = 0; n_we = 0; n_sb = 0; n_mc = 0; key_idx = 0;
      prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            n_load = 0; n_we = 0; n_sb = 0; n_mc = 0; key_idx = 0;
            prev_ov = 1'b0;
         end else begin
            if (load_en) begin
               n_load++;
               if (exp_q.size() > 0) checkOutput("load_cycle", cyc, exp_q[0]);
               else checkOutput("load_unexpected", 1, 0);
            end
            if (state_we) n_we++;
            if (sb_en) n_sb++;
            if (mc_bypass) begin
               n_mc++;
               checkOutput("mc_round", round, NUM_ROUNDS);
            end
            if (key_step) begin
               if (key_idx < NUM_ROUNDS) begin
                  checkOutput("key_round", round, key_idx + 1);
                  checkOutput("key_rcon", rcon, RCON_EXP[key_idx]);
                  checkOutput("key_col", col_sel, 0);
               end else begin
                  checkOutput("key_extra", key_idx, NUM_ROUNDS - 1);
               end
               key_idx++;
            end
            if (out_valid && !prev_ov) begin
               if (exp_q.size() == 0) begin
                  checkOutput("out_unexpected", 1, 0);
               end else begin
                  a = exp_q.pop_front();
                  checkOutput("latency", cyc - a, LATENCY);
               end
               checkOutput("load_count", n_load, 1);
               checkOutput("state_we_count", n_we, CPR * (NUM_ROUNDS + 1));
               checkOutput("sb_en_count", n_sb, CPR * NUM_ROUNDS);
               checkOutput("mc_bypass_count", n_mc, CPR);
               checkOutput("key_step_count", key_idx, NUM_ROUNDS);
               n_load = 0; n_we = 0; n_sb = 0; n_mc = 0; key_idx = 0;
            end
            if (out_valid) begin
               checkOutput("hold_round", round, NUM_ROUNDS);
               checkOutput("hold_col", col_sel, CPR - 1);
               checkOutput("hold_in_ready", in_ready, 0);
               checkOutput("hold_load_en", load_en, 0);
               checkOutput("hold_busy", busy, 1);
            end
            if (done) begin
               checkOutput("done_after_valid", prev_ov, 1);
               checkOutput("done_out_valid_low", out_valid, 0);
               checkOutput("done_in_ready", in_ready, 1);
               seen_dones++;
            end
            prev_ov = out_valid;
         end
      end
   end

   initial begin : driver
      int a, prev_a, n;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", in_ready, 0);
      checkOutput("reset_outputs", 32'(other_outs), 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_in_ready", in_ready, 1);
      checkOutput("idle_outputs", 32'(other_outs), 0);
      @(posedge clk);
      #1;

      $display("[TB] single job, consumer always ready");
      out_ready = 1'b1;
      applyStimulus(a, 1'b0);
      waitDone();

      $display("[TB] backpressure with in_valid held high");
      out_ready = 1'b0;
      applyStimulus(a, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 200);
      checkOutput("bp_out_valid_seen", out_valid, 1);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      applyStimulus(a, 1'b0);
      waitDone();

      $display("[TB] back-to-back jobs");
      prev_a = 0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(a, 1'b1);
         if (i > 0) checkOutput("accept_spacing", a - prev_a, SPACING);
         prev_a = a;
      end
      in_valid = 1'b0;
      waitDone();

      $display("[TB] reset during round 5");
      applyStimulus(a, 1'b0);
      repeat (23) @(posedge clk);
      #1;
      checkOutput("pre_reset_round", round, 5);
      checkOutput("pre_reset_col", col_sel, 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("post_reset_in_ready", in_ready, 1);
      checkOutput("post_reset_outputs", 32'(other_outs), 0);
      exp_q.delete();
      expected_dones--;
      @(posedge clk);
      #1;
      applyStimulus(a, 1'b0);
      waitDone();

      $display("[TB] in_valid pulses while busy");
      applyStimulus(a, 1'b0);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitDone();
      repeat (3) @(posedge clk);
      #1;

      checkOutput("done_count", seen_dones, expected_dones);
      checkOutput("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      n_fails++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
